// File: rtl/seq_detector_cfg.sv
// seq_detector_cfg: run-time programmable serial bit-pattern detector with a saturating match counter.
module seq_detector_cfg #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 COUNT_W     = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               match,
    output logic               nmatch,
    output logic               idle,
    output logic               cfg_err,
    output logic [COUNT_W-1:0] match_count
);
    logic [MAX_LEN-1:0] hist_q, hist_d, pattern_q, pattern_d, hist_n, mask;
    logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d, fill_inc;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               overlap_q, overlap_d, match_q, match_d, cfg_err_q, cfg_err_d;
    logic               cfg_ok, acc, hit;

    always_comb begin
        cfg_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        acc       = bit_valid && !cfg_we;
        hist_n    = {hist_q[MAX_LEN-2:0], bit_in};
        fill_inc  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        // shifting all-ones by len leaves zeros exactly in the compared low bits
        mask      = ~({MAX_LEN{1'b1}} << len_q);
        hit       = acc && (fill_inc >= len_q) && (((hist_n ^ pattern_q) & mask) == '0);
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        if (cfg_we && cfg_ok) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (acc) begin
            hist_d = hist_n;
            fill_d = (hit && !overlap_q) ? '0 : fill_inc;
        end
        match_d   = hit;
        cfg_err_d = cfg_we && !cfg_ok;
        count_d   = clr_count ? '0 : (hit && !(&count_q)) ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= RST_PATTERN;
            len_q     <= LEN_W'(RST_LEN);
            overlap_q <= RST_OVERLAP;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
            count_q   <= count_d;
        end
    end

    assign match       = match_q;
    assign nmatch      = ~match_q;
    assign idle        = (fill_q == '0);
    assign cfg_err     = cfg_err_q;
    assign match_count = count_q;
endmodule

// File: doc/seq_detector_cfg.md
Name: seq_detector_cfg

Overview:
- Parametrised, run-time-programmable serial bit-pattern detector. It succeeds the fixed hard-wired Moore sequence-detector user modules.
- Pattern, length (1..MAX_LEN) and overlap mode are loaded through a config strobe.
- It gates serial input with a valid strobe, pulses `match`, and keeps a saturating match counter.
- It sits behind the Tiny Tapeout io pin wrapper: serial bit in, status flags out.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- COUNT_W, 8: width of the match counter.
- RST_PATTERN, 8'b0000_1011: pattern after reset. Width MAX_LEN, right-aligned.
- RST_LEN, 4: pattern length after reset (1..MAX_LEN).
- RST_OVERLAP, 1: overlap mode after reset.
- LEN_W (localparam): $clog2(MAX_LEN+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is sampled on this edge when high.
- cfg_we  in  1  single-cycle config write strobe.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned; bit[len-1] is the first bit received.
- cfg_len  in  LEN_W  new pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- clr_count  in  1  synchronous clear of match_count.
- match  out  1  one-cycle pulse: pattern detected.
- nmatch  out  1  ~match.
- idle  out  1  no bits buffered (fill == 0).
- cfg_err  out  1  one-cycle pulse: rejected config write.
- match_count  out  COUNT_W  saturating count of matches.

Behaviour:
- **Reset.** While rst_n is low, all of the following hold immediately, independent of clk, including mid-pattern:
  - hist = 0, fill = 0
  - match = 0, nmatch = 1, idle = 1, cfg_err = 0, match_count = 0
  - pattern = RST_PATTERN, len = RST_LEN, overlap = RST_OVERLAP
- **State.**
  - hist[MAX_LEN-1:0] is the shift history.
  - fill[LEN_W-1:0] counts buffered bits and saturates at MAX_LEN.
- **Accepted bit** (bit_valid=1 and cfg_we=0):
  - hist_n = {hist[MAX_LEN-2:0], bit_in}.
  - fill_n = min(fill+1, MAX_LEN).
  - mask = (1<<len)-1.
  - hit = (fill_n >= len) && ((hist_n & mask) == (pattern & mask)).
- **Match timing.**
  - match is registered: it is high for exactly the one cycle after the edge that accepted the completing bit (latency 1).
  - With bit_valid low, hist and fill hold and match = 0.
  - Gaps in bit_valid do not break a partial match.
- **Overlap mode.**
  - overlap=1: on hit, fill advances normally, so the suffix of a match can start the next one.
  - overlap=0: on hit, fill <= 0; hist still updates.
- **Counter.**
  - match_count increments on each hit and saturates at 2^COUNT_W-1 (no wrap).
  - clr_count clears it to 0 and wins over a simultaneous hit.
  - clr_count does not affect hist or fill.
- **Config write** (cfg_we=1):
  - Valid when 1 <= cfg_len <= MAX_LEN. Then pattern, len and overlap load; hist <= 0, fill <= 0; match_count is unchanged.
  - A bit_valid in the same cycle is dropped, and match is 0 next cycle.
  - Invalid when cfg_len == 0 or cfg_len > MAX_LEN. Then config and state are unchanged, the bit (if any) is still dropped, and cfg_err = 1 for one cycle.
- **Derived outputs.** idle = (fill == 0) and is registered with fill. nmatch is the combinational inverse of match.
- **len = 1:** every accepted bit equal to pattern[0] produces a match. In non-overlap mode this is identical.
- **Datapath.** Single always_ff block on posedge clk / negedge rst_n. No combinational path from inputs to outputs.

Test Plan:
- Reset defaults (1011, len 4, overlap), stream 1,0,1,1,0,1,1 with bit_valid every cycle:
  - match pulses the cycle after bits 4 and 7.
  - match_count = 2.
  - nmatch is low only on those cycles.
  - idle goes 1→0 after the first bit.
- Load cfg_overlap=0, same pattern, same stream:
  - match only after bit 4.
  - idle = 1 the cycle after the match.
  - match_count increments by 1.
- Same stream with 0–3 idle cycles inserted between bits:
  - match timing shifts with the valid edges.
  - no spurious pulses.
  - count result is identical.
- Config errors and long pattern:
  - cfg_len = 0 → cfg_err pulses; the default stream still matches as 1011.
  - cfg_len = 9 → same.
  - Load 8'hFF, len 8, overlap=1; feed 9 ones → match after bits 8 and 9.
  - A bit_valid coincident with cfg_we is dropped.
- Counter saturation and clear, with COUNT_W = 2:
  - 5 matches → match_count holds at 3.
  - clr_count asserted on the same edge as a hit → 0.
  - The next hit → 1.
- Async reset mid-stream:
  - After 3 of 4 pattern bits, drop rst_n between edges → outputs reach reset values immediately.
  - Release reset and feed the 4th bit only → no match.
  - A full 1011 → match, count = 1.
